// File: rtl/otfc_pkg.sv
// Shared definitions for the on-the-fly conversion blocks: the signed-digit
// encoding and the result converter state encoding.
package otfc_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } otfc_state_e;

endpackage

// File: rtl/otfc_result_converter_if.sv
// Digit stream in, binary result out with valid/ready. The slave modport is the
// converter side and the master modport is the producer/consumer side.
interface otfc_result_converter_if #(
  parameter int DIGITS = 64
);
  logic              digit_valid;
  logic [1:0]        p_value;
  logic [DIGITS:0]   result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output digit_valid, p_value, result_ready,
    input  result, result_valid
  );

  modport slave (
    input  digit_valid, p_value, result_ready,
    output result, result_valid
  );
endinterface

// File: rtl/otfc_digit_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair,
// where QM tracks Q minus one ulp so a negative digit never needs a borrow chain.
module otfc_digit_step
  import otfc_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] qm,
  input  logic [1:0]       digit,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] qm_next
);

  localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // The MSB shifted out is dropped; the result wraps as a two's-complement fraction.
  always_comb begin
    q_next  = q << 1;
    qm_next = (qm << 1) | LSB_ONE;
    case (digit)
      DIG_POS: begin
        q_next  = (q << 1) | LSB_ONE;
        qm_next = q << 1;
      end
      DIG_NEG: begin
        q_next  = (qm << 1) | LSB_ONE;
        qm_next = qm << 1;
      end
      default: begin
        q_next  = q << 1;
        qm_next = (qm << 1) | LSB_ONE;
      end
    endcase
  end

endmodule

// File: rtl/otfc_result_converter.sv
// Converts the MSD-first product digit stream into a two's-complement result.
// Optional build macro OTFC_DIGIT_CHECK_EN adds the sticky digit_err output.
//
// state   | meaning
// IDLE    | waiting for enable_all
// SKIP    | discarding the leading online-delay digits
// CONVERT | folding digits into Q/QM
// DONE    | result offered until result_ready
module otfc_result_converter
  import otfc_pkg::*;
#(
  parameter int DIGITS       = 64,
  parameter int ONLINE_DELAY = 3,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  enable_all,
  otfc_result_converter_if.slave bus,
  output logic                  busy
`ifdef OTFC_DIGIT_CHECK_EN
  ,
  output logic                  digit_err
`endif
);

  localparam int W = DIGITS + 1;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] SKIP    = ST_SKIP;
  localparam logic [1:0] CONVERT = ST_CONVERT;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [1:0] START_STATE = (ONLINE_DELAY > 0) ? SKIP : CONVERT;
  localparam logic [CNT_WIDTH-1:0] SKIP_LAST =
    CNT_WIDTH'((ONLINE_DELAY > 0) ? (ONLINE_DELAY - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CONV_LAST = CNT_WIDTH'(DIGITS - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         q;
  logic [W-1:0]         qm;
  logic [W-1:0]         q_next;
  logic [W-1:0]         qm_next;
  logic [W-1:0]         result_q;
  logic                 result_valid_q;

  otfc_digit_step #(.WIDTH(W)) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (bus.p_value),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      q              <= '0;
      qm             <= '1;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_all) begin
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
            state <= START_STATE;
          end
        end
        SKIP: begin
          if (bus.digit_valid) begin
            if (cnt == SKIP_LAST) begin
              cnt   <= '0;
              state <= CONVERT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CONVERT: begin
          if (bus.digit_valid) begin
            q  <= q_next;
            qm <= qm_next;
            if (cnt == CONV_LAST) begin
              result_q       <= q_next;
              result_valid_q <= 1'b1;
              cnt            <= '0;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OTFC_DIGIT_CHECK_EN
  // Redundant zero is legal for conversion but flagged for the producer.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      digit_err <= 1'b0;
    end else if (state == IDLE && enable_all) begin
      digit_err <= 1'b0;
    end else if (state == CONVERT && bus.digit_valid && bus.p_value == 2'b11) begin
      digit_err <= 1'b1;
    end
  end
`endif

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_otfc_result_converter.sv
// Scoreboard bench for otfc_result_converter with DIGITS=8, ONLINE_DELAY=2.
module tb_otfc_result_converter;
  import otfc_pkg::*;

  localparam int DIGITS = 8;
  localparam int OD     = 2;
  localparam int W      = DIGITS + 1;

  logic clk = 1'b0;
  logic asyn_reset;
  logic enable_all;
  logic busy;
`ifdef OTFC_DIGIT_CHECK_EN
  logic digit_err;
`endif

  always #5 clk = ~clk;

  otfc_result_converter_if #(.DIGITS(DIGITS)) bus ();

  otfc_result_converter #(
    .DIGITS       (DIGITS),
    .ONLINE_DELAY (OD),
    .CNT_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .enable_all (enable_all),
    .bus        (bus.slave),
    .busy       (busy)
`ifdef OTFC_DIGIT_CHECK_EN
    ,
    .digit_err  (digit_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", bus.result);
      end else begin
        check("result", bus.result, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // zmode: 0 = zeros as 00, 1 = random 00/11, 2 = zeros always as 11
  function automatic logic [1:0] enc(input int d, input int zmode);
    if (d > 0) return DIG_POS;
    if (d < 0) return DIG_NEG;
    if (zmode == 2) return 2'b11;
    if (zmode == 1 && $urandom_range(1) == 1) return 2'b11;
    return DIG_ZERO;
  endfunction

  task automatic send_frame(input int d[8], input int max_gap, input bit start_dv,
                            input int zmode, input int en_pulse_at);
    int val = 0;
    foreach (d[i]) val = val * 2 + d[i];
    exp_q.push_back(W'(val));
    enable_all      = 1'b1;
    bus.digit_valid = start_dv;
    bus.p_value     = DIG_POS;
    tick();
    enable_all      = 1'b0;
    bus.digit_valid = 1'b0;
    check("busy_after_start", W'(busy), W'(1));
    for (int j = 0; j < OD; j++) begin
      repeat ($urandom_range(max_gap)) tick();
      bus.digit_valid = 1'b1;
      bus.p_value     = 2'($urandom_range(3));
      tick();
      bus.digit_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == en_pulse_at) begin
        enable_all = 1'b1;
        tick();
        enable_all = 1'b0;
      end
      repeat ($urandom_range(max_gap)) begin
        bus.p_value = 2'($urandom_range(3));
        tick();
      end
      if (i == 7) check("valid_before_last", W'(bus.result_valid), W'(0));
      bus.digit_valid = 1'b1;
      bus.p_value     = enc(d[i], zmode);
      tick();
      bus.digit_valid = 1'b0;
    end
    check("valid_latency", W'(bus.result_valid), W'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", W'(busy), W'(0));
  endtask

  initial begin
    int rd[8];
    asyn_reset       = 1'b1;
    enable_all       = 1'b0;
    bus.digit_valid  = 1'b0;
    bus.p_value      = DIG_ZERO;
    bus.result_ready = 1'b1;
    tick();
    tick();
    check("reset_result", bus.result, '0);
    check("reset_valid", W'(bus.result_valid), W'(0));
    check("reset_busy", W'(busy), W'(0));
`ifdef OTFC_DIGIT_CHECK_EN
    check("reset_digit_err", W'(digit_err), W'(0));
`endif
    asyn_reset = 1'b0;
    tick();

    send_frame('{1, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, -1);      // 9'h080
    wait_idle();
    send_frame('{-1, -1, -1, -1, -1, -1, -1, -1}, 0, 1'b1, 0, -1); // 9'h101
    wait_idle();
    send_frame('{1, -1, 0, 0, 0, 0, 0, 0}, 1, 1'b0, 0, -1);     // 9'h040
    wait_idle();
    send_frame('{0, 1, 1, -1, 0, 1, 0, -1}, 2, 1'b0, 0, 3);     // 64+32-16+4-1 = 83
    wait_idle();

    // Backpressure: result held while ready is low; starts in DONE are dropped.
    bus.result_ready = 1'b0;
    send_frame('{1, 1, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, -1);      // 9'h0C0
    for (int k = 0; k < 10; k++) begin
      enable_all = (k == 4);
      tick();
      check("hold_result", bus.result, 9'h0C0);
      check("hold_valid", W'(bus.result_valid), W'(1));
      check("hold_busy", W'(busy), W'(1));
    end
    enable_all       = 1'b1;
    bus.result_ready = 1'b1;
    tick();
    enable_all = 1'b0;
    check("valid_drop", W'(bus.result_valid), W'(0));
    check("busy_drop", W'(busy), W'(0));
    check("result_kept", bus.result, 9'h0C0);
    tick();
    check("handshake_start_dropped", W'(busy), W'(0));

    // Abort mid-frame after 4 converted digits.
    enable_all = 1'b1;
    tick();
    enable_all = 1'b0;
    for (int j = 0; j < OD + 4; j++) begin
      bus.digit_valid = 1'b1;
      bus.p_value     = DIG_POS;
      tick();
    end
    bus.digit_valid = 1'b0;
    asyn_reset = 1'b1;
    tick();
    check("abort_result", bus.result, '0);
    check("abort_valid", W'(bus.result_valid), W'(0));
    check("abort_busy", W'(busy), W'(0));
    asyn_reset = 1'b0;
    tick();
    send_frame('{0, 0, 0, 1, 0, 0, 0, 1}, 1, 1'b0, 0, -1);      // 17
    wait_idle();

    // Redundant zero encoding: converted as zero.
    send_frame('{1, 0, -1, 0, 0, 0, 0, 1}, 0, 1'b0, 2, -1);     // 97
`ifdef OTFC_DIGIT_CHECK_EN
    check("digit_err_set", W'(digit_err), W'(1));
`endif
    wait_idle();
`ifdef OTFC_DIGIT_CHECK_EN
    send_frame('{0, 1, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, -1);      // 64
    check("digit_err_cleared", W'(digit_err), W'(0));
    wait_idle();
`endif

    for (int f = 0; f < 200; f++) begin
      foreach (rd[i]) rd[i] = int'($urandom_range(2)) - 1;
      send_frame(rd, 3, 1'($urandom_range(1)), 1, -1);
      wait_idle();
    end

    tick();
    check("scoreboard_drain", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
